plot_sink: RTL and testbench

Receiving end of the pixel-plot interface that drawing blocks (x, y, colour, plot) drive. Accepts one plot strobe per clock, clips it to the 160x120 screen, buffers it in a small FIFO and writes it to the single-port 3-bit framebuffer RAM. The RAM port is shared with the scan-out reader, which always has priority.

---
 rtl/plot_sink_pkg.sv | 31 +++
 rtl/plot_fifo.sv | 65 ++++++
 rtl/plot_sink.sv | 119 +++++++++++
 tb/tb_plot_sink.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_sink_pkg.sv
// Shared screen geometry, FIFO entry layout and arbiter state encoding
// for the pixel-plot sink.
package plot_sink_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef struct packed {
    addr_t   addr;
    colour_t colour;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_e;

  // y*160 + x without a multiplier: 160 = 128 + 32.
  function automatic addr_t pixel_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (addr_t'(y) << 7) + (addr_t'(y) << 5) + addr_t'(x);
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot entries; DEPTH must be a power of two so the
// pointers wrap naturally.
module plot_fifo
  import plot_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is not reset; count and pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/plot_sink.sv
// Pixel-plot sink: clip, buffer and write plots into the shared framebuffer
// port, yielding to scan-out reads. Optional drop counter: PLOT_SINK_DROP_CNT_EN.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_MAX      = SCREEN_W - 1,
  parameter int Y_MAX      = SCREEN_H - 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  output logic                full,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [COLOUR_W-1:0] rd_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [COLOUR_W-1:0] mem_rdata,
  output logic [7:0]          drop_count
);

  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  arb_state_e    state_q, state_d;
  addr_t         mem_addr_q, mem_addr_d;
  colour_t       mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          rd_valid_q, rd_valid_d;

  logic          in_range, push, pop;
  logic          fifo_full, fifo_empty;
  entry_t        push_entry, head_entry;

  assign in_range   = (x <= X_LIM) && (y <= Y_LIM);
  assign push_entry = '{addr: pixel_addr(x, y), colour: colour};
  assign push       = plot && in_range && (!fifo_full || pop);

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (push_entry),
    .rdata   (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Every state applies the same priority rule, so the decision is state-independent.
  always_comb begin
    state_d     = ST_IDLE;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_valid_d  = (state_q == ST_READ);
    if (rd_req)           state_d = ST_READ;
    else if (!fifo_empty) state_d = ST_WRITE;
    pop = (state_d == ST_WRITE);
    case (state_d)
      ST_READ: mem_addr_d = rd_addr;
      ST_WRITE: begin
        mem_addr_d  = head_entry.addr;
        mem_wdata_d = head_entry.colour;
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign full      = fifo_full;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rd_valid  = rd_valid_q;
  // RAM data lands in the cycle rd_valid is high; gating keeps it 0 otherwise.
  assign rd_data   = rd_valid_q ? mem_rdata : '0;

`ifdef PLOT_SINK_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (plot && !push && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: scoreboard of expected RAM writes and
// scan-out reads, a table of plot vectors, and hand-timed corner sequences.
module tb_plot_sink;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        full;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_valid;
  logic [2:0]  rd_data;
  logic [14:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_rdata;
  logic [7:0]  drop_count;

  int n_total   = 0;
  int n_pass    = 0;
  int exp_drops = 0;

`ifdef PLOT_SINK_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic [17:0] wq[$];
  logic [2:0]  rq[$];

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic        ok;
    logic [14:0] addr;
  } vec_t;
  vec_t tbl[9];

  plot_sink dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .full       (full),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  // Read-only framebuffer model; tests never read back an address they wrote.
  function automatic logic [2:0] pat(input int a);
    return (a == 19199) ? 3'd6 : 3'(a % 8);
  endfunction

  always @(posedge clock) mem_rdata <= pat(int'(mem_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    logic [17:0] e;
    logic [2:0]  r;
    if (reset_n) begin
      if (mem_we) begin
        if (wq.size() == 0) check("wr_unexpected", 32'(mem_we), 32'd0);
        else begin
          e = wq.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e[17:3]));
          check("wr_data", 32'(mem_wdata), 32'(e[2:0]));
        end
      end
      if (rd_valid) begin
        if (rq.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
        else begin
          r = rq.pop_front();
          check("rd_data", 32'(rd_data), 32'(r));
        end
      end
    end
  end

  task automatic set_plot(input logic p, input int px, input int py, input int pc);
    plot = p; x = 8'(px); y = 7'(py); colour = 3'(pc);
  endtask

  task automatic exp_write(input int px, input int py, input int pc);
    wq.push_back({15'(py * 160 + px), 3'(pc)});
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((wq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 32'(wq.size() + rq.size()), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_drops(input string name);
    check(name, 32'(drop_count), DC_EN ? 32'(exp_drops > 255 ? 255 : exp_drops) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{x: 8'd0,   y: 7'd0,   c: 3'd1, ok: 1'b1, addr: 15'd0};
    tbl[1] = '{x: 8'd159, y: 7'd119, c: 3'd7, ok: 1'b1, addr: 15'd19199};
    tbl[2] = '{x: 8'd3,   y: 7'd2,   c: 3'd5, ok: 1'b1, addr: 15'd323};
    tbl[3] = '{x: 8'd160, y: 7'd0,   c: 3'd2, ok: 1'b0, addr: 15'd0};
    tbl[4] = '{x: 8'd100, y: 7'd50,  c: 3'd3, ok: 1'b1, addr: 15'd8100};
    tbl[5] = '{x: 8'd0,   y: 7'd120, c: 3'd4, ok: 1'b0, addr: 15'd0};
    tbl[6] = '{x: 8'd159, y: 7'd0,   c: 3'd6, ok: 1'b1, addr: 15'd159};
    tbl[7] = '{x: 8'd255, y: 7'd127, c: 3'd1, ok: 1'b0, addr: 15'd0};
    tbl[8] = '{x: 8'd0,   y: 7'd119, c: 3'd2, ok: 1'b1, addr: 15'd19040};

    reset_n = 1'b0;
    set_plot(1'b0, 0, 0, 0);
    rd_req  = 1'b0;
    rd_addr = '0;
    repeat (3) @(negedge clock);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single plot: write appears two cycles later, for exactly one cycle.
    @(posedge clock); #1 set_plot(1'b1, 3, 2, 5); exp_write(3, 2, 5);
    @(negedge clock); check("lat_n0_we", 32'(mem_we), 32'd0);
    @(posedge clock); #1 set_plot(1'b0, 0, 0, 0);
    @(negedge clock); check("lat_n1_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    check("lat_n2_we", 32'(mem_we), 32'd1);
    check("lat_n2_addr", 32'(mem_addr), 32'd323);
    check("lat_n2_data", 32'(mem_wdata), 32'd5);
    @(negedge clock); check("lat_n3_we", 32'(mem_we), 32'd0);
    wait_drain();

    // Clipping: both plots discarded, no write reaches RAM.
    @(posedge clock); #1 set_plot(1'b1, 160, 0, 3);
    @(posedge clock); #1 set_plot(1'b1, 0, 120, 4);
    @(posedge clock); #1 set_plot(1'b0, 0, 0, 0);
    exp_drops += 2;
    repeat (4) @(negedge clock);
    check("clip_we", 32'(mem_we), 32'd0);
    check_drops("clip_drop_count");

    // Single read at the last address.
    @(posedge clock); #1 rd_req = 1'b1; rd_addr = 15'd19199; rq.push_back(3'd6);
    @(posedge clock); #1 rd_req = 1'b0;
    @(negedge clock);
    check("rd_n1_addr", 32'(mem_addr), 32'd19199);
    check("rd_n1_we", 32'(mem_we), 32'd0);
    check("rd_n1_valid", 32'(rd_valid), 32'd0);
    @(negedge clock);
    check("rd_n2_valid", 32'(rd_valid), 32'd1);
    check("rd_n2_data", 32'(rd_data), 32'd6);
    check("rd_n2_we", 32'(mem_we), 32'd0);
    @(negedge clock); check("rd_n3_valid", 32'(rd_valid), 32'd0);
    wait_drain();

    // Reads every cycle starve writes: 4 buffered, 2 dropped.
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1
      rd_req = 1'b1; rd_addr = 15'(10000 + i); rq.push_back(pat(10000 + i));
      if (i < 6) begin
        set_plot(1'b1, 10 + i, 10, i + 1);
        if (i < 4) exp_write(10 + i, 10, i + 1);
        else exp_drops++;
      end else set_plot(1'b0, 0, 0, 0);
      @(negedge clock);
      check("starve_we", 32'(mem_we), 32'd0);
      check("starve_full", 32'(full), (i >= 4) ? 32'd1 : 32'd0);
    end
    @(posedge clock); #1 rd_req = 1'b0;
    @(negedge clock); check("starve_last_read_we", 32'(mem_we), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); check("starve_burst_we", 32'(mem_we), 32'd1);
    end
    @(negedge clock);
    check("starve_after_we", 32'(mem_we), 32'd0);
    check("starve_after_full", 32'(full), 32'd0);
    check_drops("starve_drop_count");
    wait_drain();

    // Full FIFO, plot in the same cycle as the first pop.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1
      rd_req = 1'b1; rd_addr = 15'(10100 + i); rq.push_back(pat(10100 + i));
      set_plot(1'b1, 20 + i, 30, i + 1); exp_write(20 + i, 30, i + 1);
    end
    @(posedge clock); #1 rd_req = 1'b0; set_plot(1'b1, 24, 30, 7); exp_write(24, 30, 7);
    @(negedge clock); check("pp_full_before", 32'(full), 32'd1);
    @(posedge clock); #1 set_plot(1'b0, 0, 0, 0);
    @(negedge clock);
    check("pp_full_after", 32'(full), 32'd1);
    check("pp_we", 32'(mem_we), 32'd1);
    wait_drain();
    check("pp_full_drained", 32'(full), 32'd0);
    check_drops("pp_drop_count");

    // Table: back-to-back plots, one write per cycle.
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1 set_plot(1'b1, int'(tbl[i].x), int'(tbl[i].y), int'(tbl[i].c));
      if (tbl[i].ok) wq.push_back({tbl[i].addr, tbl[i].c});
      else exp_drops++;
      @(negedge clock); check("tbl_full", 32'(full), 32'd0);
    end
    @(posedge clock); #1 set_plot(1'b0, 0, 0, 0);
    wait_drain();
    check_drops("tbl_drop_count");

    // Reset with 3 entries buffered behind reads.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1
      rd_req = 1'b1; rd_addr = 15'(10200 + i); rq.push_back(pat(10200 + i));
      if (i < 3) set_plot(1'b1, 40 + i, 5, i + 2);
      else set_plot(1'b0, 0, 0, 0);
    end
    @(negedge clock);
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    #2 reset_n = 1'b0;
    wq.delete();
    rq.delete();
    rd_req = 1'b0;
    exp_drops = 0;
    #1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_data", 32'(rd_data), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_drops", 32'(drop_count), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("post_rst_we", 32'(mem_we), 32'd0);
      check("post_rst_valid", 32'(rd_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
